// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin fetch/execute arbiter and clear sequencer for a single-port RAM
module ram_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int CLR_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    output logic          f_valid,
    input  logic          e_req,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wdata,
    output logic          e_ack,
    output logic [DW-1:0] e_rdata,
    output logic          e_valid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_datain,
    output logic          ram_enable,
    output logic          ram_read_en,
    output logic          ram_write_en,
    output logic          ram_clear,
    input  logic [DW-1:0] ram_dataout,
    output logic          busy
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    logic          pending;
    logic          last_f;
    logic          sel_e;
    logic          we_r;
    logic [CW-1:0] cnt;
    logic          win_e;

    // execute wins when alone, or on a tie when fetch was granted last
    assign win_e = e_req & (~f_req | last_f);

    // single sequencer: arbitration, RAM command generation and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            last_f       <= 1'b1;
            sel_e        <= 1'b0;
            we_r         <= 1'b0;
            cnt          <= '0;
            f_ack        <= 1'b0;
            f_rdata      <= '0;
            f_valid      <= 1'b0;
            e_ack        <= 1'b0;
            e_rdata      <= '0;
            e_valid      <= 1'b0;
            ram_addr     <= '0;
            ram_datain   <= '0;
            ram_enable   <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            ram_clear    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            f_ack   <= 1'b0;
            e_ack   <= 1'b0;
            f_valid <= 1'b0;
            e_valid <= 1'b0;
            if (state != IDLE && clr_req) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending || clr_req) begin
                        state      <= CLEAR;
                        pending    <= 1'b0;
                        cnt        <= CW'(CLR_CYCLES - 1);
                        ram_enable <= 1'b1;
                        ram_clear  <= 1'b1;
                        busy       <= 1'b1;
                    end else if (f_req || e_req) begin
                        if (win_e) begin
                            sel_e        <= 1'b1;
                            we_r         <= e_we;
                            ram_addr     <= e_addr;
                            ram_datain   <= e_wdata;
                            ram_read_en  <= ~e_we;
                            ram_write_en <= e_we;
                            e_ack        <= 1'b1;
                            last_f       <= 1'b0;
                        end else begin
                            sel_e        <= 1'b0;
                            we_r         <= 1'b0;
                            ram_addr     <= f_addr;
                            ram_read_en  <= 1'b1;
                            ram_write_en <= 1'b0;
                            f_ack        <= 1'b1;
                            last_f       <= 1'b1;
                        end
                        ram_enable <= 1'b1;
                        state      <= ACCESS;
                        busy       <= 1'b1;
                    end
                end
                ACCESS: begin
                    ram_enable   <= 1'b0;
                    ram_read_en  <= 1'b0;
                    ram_write_en <= 1'b0;
                    if (we_r) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (sel_e) begin
                        e_rdata <= ram_dataout;
                        e_valid <= 1'b1;
                    end else begin
                        f_rdata <= ram_dataout;
                        f_valid <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                CLEAR: begin
                    if (cnt == '0) begin
                        ram_enable <= 1'b0;
                        ram_clear  <= 1'b0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CLR_CYCLES = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clr_req = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_ack;
    logic [DW-1:0] f_rdata;
    logic          f_valid;
    logic          e_req = 1'b0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic          e_ack;
    logic [DW-1:0] e_rdata;
    logic          e_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_datain;
    logic          ram_enable;
    logic          ram_read_en;
    logic          ram_write_en;
    logic          ram_clear;
    bit   [DW-1:0] ram_dataout;
    logic          busy;

    bit   [DW-1:0] mem [256];

    int total = 0;
    int bad = 0;

    ram_arbiter #(.AW(AW), .DW(DW), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk(clk), .reset(reset), .clr_req(clr_req),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_valid(f_valid),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_ack(e_ack), .e_rdata(e_rdata), .e_valid(e_valid),
        .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_enable(ram_enable),
        .ram_read_en(ram_read_en), .ram_write_en(ram_write_en), .ram_clear(ram_clear),
        .ram_dataout(ram_dataout), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural single-port RAM: dataout updates on the edge ending the access
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_clear) begin
                foreach (mem[i]) mem[i] <= '0;
            end else if (ram_write_en) begin
                mem[ram_addr] <= ram_datain;
            end else if (ram_read_en) begin
                ram_dataout <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ewrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        e_req = 1'b1; e_we = 1'b1; e_addr = a; e_wdata = d;
        step();
        chk("wr_ack", e_ack, 1);
        chk("wr_we", ram_write_en, 1);
        chk("wr_data", ram_datain, d);
        e_req = 1'b0; e_we = 1'b0;
        step();
        chk("wr_idle", {busy, ram_write_en, e_ack}, 0);
    endtask

    initial begin
        int grants, fv, ev, dbl, both, acks, fa, vf;
        logic [3:0] order;
        logic pf, pe;
        int ac [3];

        // reset state
        step();
        chk("rst_outs", {f_ack, f_valid, e_ack, e_valid, ram_enable, ram_read_en,
                         ram_write_en, ram_clear, busy}, 0);
        chk("rst_data", {f_rdata, e_rdata}, 0);
        chk("rst_addr", {ram_addr, ram_datain}, 0);
        reset = 1'b0;
        step();

        // preload and fetch read
        ewrite(8'h01, 16'h1234);
        f_req = 1'b1; f_addr = 8'h01;
        step();
        chk("f_ack", f_ack, 1);
        chk("f_rd_en", {ram_enable, ram_read_en, ram_write_en}, 3'b110);
        chk("f_addr", ram_addr, 8'h01);
        chk("f_no_eack", e_ack, 0);
        f_req = 1'b0;
        step();
        chk("f_resp", {f_ack, f_valid, ram_enable, busy}, 4'b0001);
        step();
        chk("f_valid", f_valid, 1);
        chk("f_rdata", f_rdata, 16'h1234);
        chk("f_no_evalid", e_valid, 0);
        chk("f_idle", busy, 0);
        step();
        chk("f_valid_pulse", f_valid, 0);

        // write then read on execute
        e_req = 1'b1; e_we = 1'b1; e_addr = 8'h10; e_wdata = 16'h00AA;
        step();
        chk("w_ack", {e_ack, ram_write_en, ram_read_en}, 3'b110);
        chk("w_data", ram_datain, 16'h00AA);
        e_we = 1'b0;
        step();
        chk("w_single", {e_ack, ram_write_en, busy}, 0);
        step();
        chk("r_ack", {e_ack, ram_read_en, ram_write_en}, 3'b110);
        e_req = 1'b0;
        step();
        chk("r_resp", {e_ack, e_valid}, 0);
        step();
        chk("r_valid", e_valid, 1);
        chk("r_rdata", e_rdata, 16'h00AA);
        chk("r_f_hold", f_rdata, 16'h1234);
        step();
        chk("r_valid_pulse", e_valid, 0);

        // clear requested during a fetch read, execute queued behind it
        f_req = 1'b1; f_addr = 8'h01;
        step();
        chk("c_fack", f_ack, 1);
        clr_req = 1'b1; f_req = 1'b0; e_req = 1'b1; e_we = 1'b0; e_addr = 8'h10;
        step();
        clr_req = 1'b0;
        chk("c_resp", {ram_clear, e_ack}, 0);
        step();
        chk("c_fvalid", f_valid, 1);
        chk("c_fdata", f_rdata, 16'h1234);
        chk("c_not_yet", ram_clear, 0);
        step();
        chk("c_clr1", {ram_clear, ram_enable, e_ack, busy}, 4'b1101);
        step();
        chk("c_clr2", {ram_clear, ram_enable, e_ack}, 3'b110);
        step();
        chk("c_done", {ram_clear, ram_enable, busy}, 0);
        step();
        chk("c_eack", e_ack, 1);
        e_req = 1'b0;
        step();
        step();
        chk("c_evalid", e_valid, 1);
        chk("c_cleared", e_rdata, 0);

        // contention after reset: execute wins first tie, then alternate
        ewrite(8'h01, 16'h1234);
        ewrite(8'h10, 16'h00AA);
        reset = 1'b1;
        step();
        reset = 1'b0;
        f_req = 1'b1; e_req = 1'b1; e_we = 1'b0; f_addr = 8'h01; e_addr = 8'h10;
        grants = 0; fv = 0; ev = 0; dbl = 0; both = 0; order = '0; pf = 0; pe = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (f_ack && e_ack) both++;
            if ((f_ack && pf) || (e_ack && pe)) dbl++;
            pf = f_ack; pe = e_ack;
            if (f_ack || e_ack) begin
                if (grants < 4) order[grants] = e_ack;
                grants++;
                if (grants == 4) begin
                    f_req = 1'b0; e_req = 1'b0;
                end
            end
            if (f_valid) fv++;
            if (e_valid) ev++;
        end
        chk("ct_grants", grants, 4);
        chk("ct_order", order, 4'b0101);
        chk("ct_pulse", {dbl[15:0], both[15:0]}, 0);
        chk("ct_valids", {fv[15:0], ev[15:0]}, {16'd2, 16'd2});
        chk("ct_data", {f_rdata, e_rdata}, {16'h1234, 16'h00AA});

        // reset during RESP of a fetch read
        f_req = 1'b1; f_addr = 8'h01;
        step();
        chk("rr_ack", f_ack, 1);
        f_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rr_outs", {f_ack, f_valid, e_ack, e_valid, ram_enable, ram_read_en,
                        ram_write_en, ram_clear, busy}, 0);
        chk("rr_data", {f_rdata, ram_addr}, 0);
        step();
        reset = 1'b0;
        vf = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (f_valid) vf++;
        end
        chk("rr_no_valid", vf, 0);
        f_req = 1'b1; e_req = 1'b1; e_we = 1'b0;
        step();
        chk("rr_tie", {e_ack, f_ack}, 2'b10);
        f_req = 1'b0; e_req = 1'b0;
        step();
        step();
        step();

        // execute streaming reads alone
        e_req = 1'b1; e_we = 1'b0; e_addr = 8'h10;
        acks = 0; fa = 0; ac[0] = 0; ac[1] = 0; ac[2] = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (f_ack) fa++;
            if (e_ack) begin
                if (acks < 3) ac[acks] = c;
                acks++;
                if (acks == 3) e_req = 1'b0;
            end
        end
        chk("st_acks", acks, 3);
        chk("st_gap1", ac[1] - ac[0], 3);
        chk("st_gap2", ac[2] - ac[1], 3);
        chk("st_no_fack", fa, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
